// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: tracks in-flight writers from EX to WB, raises
// stall on RAW hazards (or load-use only when forwarding exists), counts stalls/flushes.
module pipe_hazard_ctrl #(
  parameter int unsigned AW     = 5,
  parameter int unsigned STAGES = 3,
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs1,
  input  logic [AW-1:0]        id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_rd_we,
  input  logic                 id_is_load,
  input  logic                 flush,
  output logic                 stall,
  output logic                 issue,
  output logic                 wb_valid,
  output logic                 wb_we,
  output logic [AW-1:0]        wb_rd,
  output logic [(2**AW)-1:0]   busy_mask,
  output logic [CW-1:0]        stall_count,
  output logic [CW-1:0]        flush_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] we_q;
  logic [STAGES-1:0] ld_q;
  logic [AW-1:0]     rd_q [STAGES];
  logic [STAGES-1:0] hit;
  logic              hazard;

  // Per-stage source match; x0 is excluded on the source side and never written as we=1.
  always_comb begin
    hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit[k] = v_q[k] & we_q[k] &
               ((id_rs1_used & (id_rs1 != '0) & (rd_q[k] == id_rs1)) |
                (id_rs2_used & (id_rs2 != '0) & (rd_q[k] == id_rs2)));
    end
    hazard = (FWD_EN != 0) ? (hit[0] & ld_q[0]) : (|hit);
  end

  assign stall = id_valid & hazard & ~flush;
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (v_q[k] & we_q[k]) busy_mask[rd_q[k]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

  // Entry chain advances every cycle; stages behind decode never hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      we_q <= '0;
      ld_q <= '0;
      for (int k = 0; k < STAGES; k++) rd_q[k] <= '0;
    end else begin
      v_q[0]  <= issue;
      we_q[0] <= issue & id_rd_we & (id_rd != '0);
      ld_q[0] <= issue & id_is_load;
      rd_q[0] <= issue ? id_rd : '0;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        we_q[k] <= we_q[k-1];
        ld_q[k] <= ld_q[k-1];
        rd_q[k] <= rd_q[k-1];
      end
    end
  end

  assign wb_valid = v_q[STAGES-1];
  assign wb_we    = we_q[STAGES-1];
  assign wb_rd    = rd_q[STAGES-1];

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != CNT_MAX)) stall_count <= stall_count + CW'(1);
      if (flush && (flush_count != CNT_MAX)) flush_count <= flush_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three configurations share stimulus and are checked
// every cycle against a queue-of-issued-instructions reference model.
module tb_pipe_hazard_ctrl;

  localparam int ST = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        st_o [3];
  logic        is_o [3];
  logic        wv_o [3];
  logic        ww_o [3];
  logic [4:0]  wr_o [3];
  logic [31:0] bm_o [3];
  logic [15:0] sc_o [2];
  logic [15:0] fc_o [2];
  logic [3:0]  sc2, fc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.AW(5), .STAGES(ST), .FWD_EN(0), .CW(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .flush(flush), .stall(st_o[0]), .issue(is_o[0]),
    .wb_valid(wv_o[0]), .wb_we(ww_o[0]), .wb_rd(wr_o[0]), .busy_mask(bm_o[0]),
    .stall_count(sc_o[0]), .flush_count(fc_o[0]));

  pipe_hazard_ctrl #(.AW(5), .STAGES(ST), .FWD_EN(1), .CW(16)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .flush(flush), .stall(st_o[1]), .issue(is_o[1]),
    .wb_valid(wv_o[1]), .wb_we(ww_o[1]), .wb_rd(wr_o[1]), .busy_mask(bm_o[1]),
    .stall_count(sc_o[1]), .flush_count(fc_o[1]));

  pipe_hazard_ctrl #(.AW(5), .STAGES(ST), .FWD_EN(0), .CW(4)) u2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .flush(flush), .stall(st_o[2]), .issue(is_o[2]),
    .wb_valid(wv_o[2]), .wb_we(ww_o[2]), .wb_rd(wr_o[2]), .busy_mask(bm_o[2]),
    .stall_count(sc2), .flush_count(fc2));

  // Reference model: every issued instruction with the cycle it issued in.
  // Issued in cycle c -> occupies stage (t-c-1) during cycle t; in flight while 1 <= t-c <= ST.
  typedef struct {
    int         inst;
    int         cyc;
    logic [4:0] rd;
    bit         we;
    bit         ld;
  } rec_t;

  rec_t recs[$];
  int   t = 0;
  int   sc_m [3];
  int   fc_m [3];

  function automatic int cnt_max(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return (id_rs1_used && id_rs1 != 5'd0 && id_rs1 == r) ||
           (id_rs2_used && id_rs2 != 5'd0 && id_rs2 == r);
  endfunction

  function automatic bit m_hazard(input int i);
    bit h;
    int age;
    h = 1'b0;
    foreach (recs[j]) begin
      age = t - recs[j].cyc;
      if (recs[j].inst == i && age >= 1 && age <= ST && recs[j].we && reads(recs[j].rd)) begin
        if (i != 1) h = 1'b1;
        else if (age == 1 && recs[j].ld) h = 1'b1;
      end
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: compare at negedge, advance model at the edge.
  task automatic cycle();
    bit          es [3];
    bit          ei [3];
    bit          hz;
    logic [31:0] eb;
    bit          ewv, eww;
    logic [4:0]  ewr;
    int          age;
    rec_t        r;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      hz = m_hazard(i);
      es[i] = id_valid && hz && !flush;
      ei[i] = id_valid && !es[i] && !flush;
      eb = 32'd0; ewv = 1'b0; eww = 1'b0; ewr = 5'd0;
      foreach (recs[j]) begin
        age = t - recs[j].cyc;
        if (recs[j].inst == i && age >= 1 && age <= ST) begin
          if (recs[j].we) eb[recs[j].rd] = 1'b1;
          if (age == ST) begin ewv = 1'b1; eww = recs[j].we; ewr = recs[j].rd; end
        end
      end
      chk($sformatf("stall%0d@%0d", i, t), 32'(st_o[i]), 32'(es[i]));
      chk($sformatf("issue%0d@%0d", i, t), 32'(is_o[i]), 32'(ei[i]));
      chk($sformatf("wb_valid%0d@%0d", i, t), 32'(wv_o[i]), 32'(ewv));
      chk($sformatf("wb_we%0d@%0d", i, t), 32'(ww_o[i]), 32'(eww));
      chk($sformatf("wb_rd%0d@%0d", i, t), 32'(wr_o[i]), 32'(ewr));
      chk($sformatf("busy%0d@%0d", i, t), bm_o[i], eb);
      if (i == 2) begin
        chk($sformatf("scnt%0d@%0d", i, t), {28'd0, sc2}, 32'(sc_m[i]));
        chk($sformatf("fcnt%0d@%0d", i, t), {28'd0, fc2}, 32'(fc_m[i]));
      end else begin
        chk($sformatf("scnt%0d@%0d", i, t), 32'(sc_o[i]), 32'(sc_m[i]));
        chk($sformatf("fcnt%0d@%0d", i, t), 32'(fc_o[i]), 32'(fc_m[i]));
      end
    end
    if (rst) begin
      recs.delete();
      for (int i = 0; i < 3; i++) begin sc_m[i] = 0; fc_m[i] = 0; end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ei[i]) begin
          r.inst = i; r.cyc = t; r.rd = id_rd;
          r.we = id_rd_we && (id_rd != 5'd0); r.ld = id_is_load;
          recs.push_back(r);
        end
        if (es[i] && sc_m[i] < cnt_max(i)) sc_m[i]++;
        if (flush && fc_m[i] < cnt_max(i)) fc_m[i]++;
      end
    end
    t++;
    for (int j = recs.size() - 1; j >= 0; j--)
      if (t - recs[j].cyc > ST) recs.delete(j);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit fl);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_rd_we = we; id_is_load = ld; flush = fl;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_stall", 32'(st_o[0]), 32'd0);
    chk("rst_wbv", 32'(wv_o[0]), 32'd0);
    chk("rst_busy", bm_o[0], 32'd0);
    chk("rst_scnt", 32'(sc_o[0]), 32'd0);
    chk("rst_fcnt", 32'(fc_o[0]), 32'd0);
    idle(1);

    // RAW: A writes x5, B reads x5 for four cycles
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); cycle();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
    for (int k = 0; k < 4; k++) cycle();
    chk("raw_scnt_fwd0", 32'(sc_o[0]), 32'd3);
    chk("raw_scnt_fwd1", 32'(sc_o[1]), 32'd0);
    idle(4);

    // x0 never busy and never a hazard
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    chk("x0_busy", bm_o[0], 32'd0);
    drive(1, 0, 1, 0, 1, 3, 0, 0, 0); cycle();
    idle(4);

    // Flush overrides a pending hazard
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); cycle();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 1); cycle();
    idle(4);
    chk("flush_cnt", 32'(fc_o[0]), 32'd1);

    // Load-use vs. plain dependency with forwarding
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); cycle();
    drive(1, 0, 0, 7, 1, 9, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle();
    idle(4);
    chk("loaduse_scnt", 32'(sc_o[1]), 32'd1);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); cycle();
    drive(1, 0, 0, 7, 1, 9, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle();
    idle(4);
    chk("nonload_scnt", 32'(sc_o[1]), 32'd1);

    // Mid-operation reset drops in-flight writers
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); cycle();
    chk("mid_busy_pre", bm_o[0], 32'h20);
    do_reset();
    chk("mid_busy_post", bm_o[0], 32'd0);
    idle(2);

    // Saturation: self-dependent instruction held 40 cycles -> 30 stall cycles
    drive(1, 5, 1, 0, 0, 5, 1, 0, 0);
    for (int k = 0; k < 40; k++) cycle();
    chk("sat_cw4", {28'd0, sc2}, 32'd15);
    chk("sat_cw16", 32'(sc_o[0]), 32'd30);
    idle(4);

    // Randomized traffic over a small register window
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
            1'($urandom), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      cycle();
    end
    rst = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
